demux_reg: RTL

DEMUX_REG -- requirements
Module: demux_reg

---
 rtl/demux_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-N_OUTS demultiplexer with one holding slot per
// output channel. Each slot is a valid bit plus a WIDTH-bit payload and drains
// independently through its own valid/ready handshake.
//
// Optional feature macro: DEMUX_OOB_ERR_EN
//   When defined, adds the sticky err_oob output. It is set by any accepted
//   entry whose select is out of range (only possible when N_OUTS is not a
//   power of two). Without the macro such entries are silently dropped.
module demux_reg #(
    parameter int WIDTH     = 1,
    parameter int N_OUTS    = 2,
    localparam int SEL_WIDTH = $clog2(N_OUTS)
) (
    input  logic                      clk,
    input  logic                      rst_aL,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_WIDTH-1:0]      in_sel,
    input  logic [WIDTH-1:0]          in_data,
    output logic [N_OUTS-1:0]         out_valid,
    input  logic [N_OUTS-1:0]         out_ready,
    output logic [N_OUTS*WIDTH-1:0]   out_data
`ifdef DEMUX_OOB_ERR_EN
    ,
    output logic                      err_oob
`endif
);

    // One-hot decode of in_sel; all-zero means the select is out of range.
    logic [N_OUTS-1:0] sel_match;
    // Slot can take a new entry: empty now, or being released this cycle.
    logic [N_OUTS-1:0] slot_free;
    logic              sel_legal;
    logic              sel_free;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUTS; gi++) begin : g_slot
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic             release_now;
            logic             write_now;

            assign sel_match[gi] = (in_sel == SEL_WIDTH'(gi));
            assign release_now   = valid_reg & out_ready[gi];
            assign slot_free[gi] = ~valid_reg | out_ready[gi];
            assign write_now     = accept & sel_match[gi];

            // Slot state: flush beats everything, a refill beats a release
            // so a same-cycle release+refill leaves the new payload valid.
            always_ff @(posedge clk or negedge rst_aL) begin
                if (!rst_aL) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (write_now) begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end else if (release_now) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]                   = valid_reg;
            assign out_data[gi*WIDTH +: WIDTH]     = data_reg;
        end
    endgenerate

    assign sel_legal = |sel_match;
    assign sel_free  = |(sel_match & slot_free);

    // Ready ignores in_valid. Illegal selects are always consumed (and
    // dropped) so a bad entry can never wedge the upstream producer.
    assign in_ready = rst_aL & ~flush & (sel_free | ~sel_legal);
    assign accept   = in_valid & in_ready;

`ifdef DEMUX_OOB_ERR_EN
    // Sticky out-of-range flag; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            err_oob <= 1'b0;
        end else if (accept && !sel_legal) begin
            err_oob <= 1'b1;
        end
    end
`endif

endmodule
